// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises words from a show-ahead FIFO onto a UART TX line.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_ready,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_data_out,
   output logic                 fifo_read,
   output logic                 serial_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] LP_CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);
   localparam logic [IW-1:0] LP_IDX_MAX  = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LP_IDX_ONE  = IW'(1);
   localparam logic          LP_STOP_MAX = 1'(STOP_BITS - 1);

   // Elaboration-time guards on the legal parameter ranges.
   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_po
      $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic                  r_stop;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_tx;
   logic                  r_read;
   logic                  r_busy;
   logic                  r_done;

   state_t                w_state;
   logic [CW-1:0]         w_cnt;
   logic [IW-1:0]         w_idx;
   logic                  w_stop;
   logic [DATA_BITS-1:0]  w_shift;
   logic                  w_tx;
   logic                  w_read;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_load;
   logic                  w_accept;
   logic                  w_cnt_end;

   assign w_accept  = ~fifo_empty & tx_ready;
   assign w_cnt_end = (r_cnt == LP_CNT_MAX);

`ifdef UART_TX_PARITY_EN
   logic w_parity;
   // The shift register rotates, so its XOR always equals the latched word's.
   assign w_parity = (^r_shift) ^ 1'(PARITY_ODD);
`endif

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idx   = r_idx;
      w_stop  = r_stop;
      w_shift = r_shift;
      w_tx    = r_tx;
      w_read  = 1'b0;
      w_busy  = r_busy;
      w_done  = 1'b0;
      w_load  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx   = 1'b1;
            w_busy = 1'b0;
            w_cnt  = '0;
            w_idx  = '0;
            w_stop = 1'b0;
            if (w_accept) begin
               w_load = 1'b1;
            end
         end

         S_START: begin
            if (w_cnt_end) begin
               w_cnt   = '0;
               w_idx   = '0;
               w_state = S_DATA;
               w_tx    = r_shift[0];
            end else begin
               w_cnt = r_cnt + LP_CNT_ONE;
            end
         end

         S_DATA: begin
            if (w_cnt_end) begin
               w_cnt = '0;
               if (r_idx == LP_IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
                  w_state = S_PARITY;
                  w_tx    = w_parity;
`else
                  w_state = S_STOP;
                  w_tx    = 1'b1;
                  w_stop  = 1'b0;
`endif
               end else begin
                  w_idx   = r_idx + LP_IDX_ONE;
                  w_shift = {r_shift[0], r_shift[DATA_BITS-1:1]};
                  w_tx    = r_shift[1];
               end
            end else begin
               w_cnt = r_cnt + LP_CNT_ONE;
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_cnt_end) begin
               w_cnt   = '0;
               w_state = S_STOP;
               w_tx    = 1'b1;
               w_stop  = 1'b0;
            end else begin
               w_cnt = r_cnt + LP_CNT_ONE;
            end
         end
`endif

         S_STOP: begin
            w_tx = 1'b1;
            if (w_cnt_end) begin
               w_cnt = '0;
               if (r_stop == LP_STOP_MAX) begin
                  w_done = 1'b1;
                  if (w_accept) begin
                     w_load = 1'b1;
                  end else begin
                     w_state = S_IDLE;
                     w_busy  = 1'b0;
                     w_stop  = 1'b0;
                  end
               end else begin
                  w_stop = ~r_stop;
               end
            end else begin
               w_cnt = r_cnt + LP_CNT_ONE;
            end
         end

         default: begin
            w_state = S_IDLE;
            w_tx    = 1'b1;
            w_busy  = 1'b0;
            w_cnt   = '0;
            w_idx   = '0;
            w_stop  = 1'b0;
         end
      endcase

      // Frame accept: latch the head word, pop it, drive the start bit.
      if (w_load) begin
         w_state = S_START;
         w_cnt   = '0;
         w_idx   = '0;
         w_stop  = 1'b0;
         w_shift = fifo_data_out;
         w_tx    = 1'b0;
         w_read  = 1'b1;
         w_busy  = 1'b1;
      end
   end

   // State and output registers; reset forces the line high at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_stop  <= 1'b0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_read  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_stop  <= w_stop;
         r_shift <= w_shift;
         r_tx    <= w_tx;
         r_read  <= w_read;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign serial_out = r_tx;
   assign fifo_read  = r_read;
   assign tx_busy    = r_busy;
   assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed vector bench for uart_tx_frame.
// Covers 8N1/8N2 framing, back-to-back, flow control and reset abort.
module tb_uart_tx_frame;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_ready = 1'b0;
   logic       f_empty = 1'b1;
   logic [7:0] f_data = 8'h00;
   logic       f_read, sout, busy, done;

   int tests = 0;
   int fails = 0;
   int n_read = 0;
   int n_done = 0;
   logic [7:0] q[$];

   logic       d2_empty = 1'b1;
   logic [7:0] d2_data = 8'h00;
   logic       d2_read, d2_sout, d2_busy, d2_done;
   int         d2_words = 0;
   int         d2_pops = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
   ) dut (
      .clk(clk), .rst(rst), .tx_ready(tx_ready),
      .fifo_empty(f_empty), .fifo_data_out(f_data),
      .fifo_read(f_read), .serial_out(sout),
      .tx_busy(busy), .tx_done(done)
   );

   uart_tx_frame #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)
   ) dut2 (
      .clk(clk), .rst(rst), .tx_ready(1'b1),
      .fifo_empty(d2_empty), .fifo_data_out(d2_data),
      .fifo_read(d2_read), .serial_out(d2_sout),
      .tx_busy(d2_busy), .tx_done(d2_done)
   );

`ifdef UART_TX_PARITY_EN
   logic       d3_empty = 1'b1;
   logic       d3_read, d3_sout, d3_busy, d3_done;
   int         d3_words = 0;
   int         d3_pops = 0;

   uart_tx_frame #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(1), .PARITY_ODD(1)
   ) dut3 (
      .clk(clk), .rst(rst), .tx_ready(1'b1),
      .fifo_empty(d3_empty), .fifo_data_out(7'h01),
      .fifo_read(d3_read), .serial_out(d3_sout),
      .tx_busy(d3_busy), .tx_done(d3_done)
   );

   always @(posedge clk) if (d3_read) d3_pops++;
   always @(negedge clk) d3_empty = (d3_pops >= d3_words);
`endif

   // Show-ahead FIFO models: pop on the edge that ends the read strobe.
   always @(posedge clk) if (f_read && q.size() > 0) q.pop_front();
   always @(posedge clk) if (d2_read) d2_pops++;

   always @(negedge clk) begin
      if (f_read) n_read++;
      if (done) n_done++;
      f_empty = (q.size() == 0);
      f_data  = (q.size() > 0) ? q[0] : 8'h00;
      d2_empty = (d2_pops >= d2_words);
      d2_data  = (d2_pops == 0) ? 8'h3C : 8'h81;
   end

   typedef struct {
      logic [7:0]  data;
      logic [11:0] bits;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", nm, got, exp);
      end
   endtask

   // Independent frame model: bit 0 is the start bit.
   function automatic logic [11:0] frame_bits(input logic [7:0] d);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ^d;
`endif
      return f;
   endfunction

   // Waits for a start bit, then checks every cycle of one frame.
   task automatic check_frame(input string nm, input logic [11:0] exp,
                              input logic more, output int waited);
      int   nbusy;
      logic ok;
      logic got;
      waited = 0;
      while (sout !== 1'b0 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      tests++;
      if (sout !== 1'b0) begin
         fails++;
         $display("FAIL %s_start: line %b required 0", nm, sout);
         return;
      end
      nbusy = 0;
      for (int b = 0; b < NB; b++) begin
         ok = 1'b1;
         got = exp[b];
         for (int c = 0; c < CPB; c++) begin
            if (sout !== exp[b]) begin
               ok = 1'b0;
               got = sout;
            end
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
         end
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL %s_bit%0d: line %b required %b",
                     nm, b, got, exp[b]);
         end
      end
      chk({nm, "_busycyc"}, nbusy, NB * CPB);
      chk({nm, "_done"}, done, 1);
      chk({nm, "_busyend"}, busy, more);
   endtask

   initial begin
      int   w;
      int   r0;
      int   d0;
      logic ok;
      logic [11:0] e;

`ifdef UART_TX_PARITY_EN
      tbl[0] = '{8'hA5, 12'h54A};
      tbl[1] = '{8'h00, 12'h400};
      tbl[2] = '{8'hFF, 12'h5FE};
      tbl[3] = '{8'h01, 12'h602};
      tbl[4] = '{8'h80, 12'h700};
`else
      tbl[0] = '{8'hA5, 12'h34A};
      tbl[1] = '{8'h00, 12'h200};
      tbl[2] = '{8'hFF, 12'h3FE};
      tbl[3] = '{8'h01, 12'h202};
      tbl[4] = '{8'h80, 12'h300};
`endif

      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("rst_line", sout, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_read", f_read, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_line", sout, 1);

      // Zero-latency accept and a full 0xA5 frame.
      tx_ready = 1'b1;
      r0 = n_read;
      d0 = n_done;
      @(posedge clk);
      #1 q.push_back(8'hA5);
      @(negedge clk);
      chk("lat_pre", sout, 1);
      @(negedge clk);
      chk("lat_start", sout, 0);
      chk("lat_busy", busy, 1);
      check_frame("a5", frame_bits(8'hA5), 1'b0, w);
      @(negedge clk);
      chk("a5_reads", n_read - r0, 1);
      chk("a5_dones", n_done - d0, 1);

      // Table of single frames.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 q.push_back(tbl[i].data);
         check_frame($sformatf("vec%0d", i), tbl[i].bits, 1'b0, w);
         repeat (2) @(negedge clk);
      end

      // Back-to-back frames with no idle gap.
      r0 = n_read;
      d0 = n_done;
      @(posedge clk);
      #1;
      q.push_back(8'h00);
      q.push_back(8'hFF);
      check_frame("b2b0", frame_bits(8'h00), 1'b1, w);
      check_frame("b2b1", frame_bits(8'hFF), 1'b0, w);
      chk("b2b_gap", w, 0);
      @(negedge clk);
      chk("b2b_reads", n_read - r0, 2);
      chk("b2b_dones", n_done - d0, 2);

      // Flow control: held off while tx_ready is low.
      tx_ready = 1'b0;
      r0 = n_read;
      @(posedge clk);
      #1 q.push_back(8'h3C);
      ok = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (sout !== 1'b1 || f_read !== 1'b0) ok = 1'b0;
      end
      chk("hold_line", ok, 1);
      chk("hold_reads", n_read - r0, 0);
      tx_ready = 1'b1;
      fork
         begin
            repeat (12) @(negedge clk);
            tx_ready = 1'b0;
            q.push_back(8'h11);
         end
      join_none
      check_frame("flow", frame_bits(8'h3C), 1'b0, w);
      chk("flow_lat", w, 1);
      r0 = n_read;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (sout !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      chk("flow_hold2", ok, 1);
      chk("flow_noread", n_read - r0, 0);
      tx_ready = 1'b1;
      check_frame("flow2", frame_bits(8'h11), 1'b0, w);
      chk("flow2_lat", w, 1);

      // Reset during data bit 3 aborts the frame and loses its word.
      @(posedge clk);
      #1;
      q.push_back(8'h96);
      q.push_back(8'h5A);
      w = 0;
      while (sout !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      repeat (17) @(negedge clk);
      chk("rstmid_pre", sout, 0);
      d0 = n_done;
      #1 rst = 1'b1;
      #1;
      chk("rstmid_line", sout, 1);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      chk("rstmid_read", f_read, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rstmid_nodone", n_done - d0, 0);
      check_frame("postrst", frame_bits(8'h5A), 1'b0, w);
      chk("postrst_lat", w, 1);
      chk("fifo_drained", q.size(), 0);

      // Two stop bits: line high 2 bit periods, then next start.
      @(posedge clk);
      #1 d2_words = 2;
      w = 0;
      while (d2_sout !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("s2_start", d2_sout, 0);
      e = frame_bits(8'h3C);
      ok = 1'b1;
      for (int c = 0; c < (NB - 1) * CPB; c++) begin
         if (d2_sout !== e[c / CPB]) ok = 1'b0;
         @(negedge clk);
      end
      chk("s2_data", ok, 1);
      ok = 1'b1;
      for (int c = 0; c < 2 * CPB; c++) begin
         if (d2_sout !== 1'b1 || d2_busy !== 1'b1) ok = 1'b0;
         @(negedge clk);
      end
      chk("s2_stops", ok, 1);
      chk("s2_next", d2_sout, 0);
      chk("s2_done", d2_done, 1);
      chk("s2_busy", d2_busy, 1);
      repeat ((NB + 1) * CPB + 2) @(negedge clk);
      chk("s2_idle", d2_busy, 0);
      chk("s2_pops", d2_pops, 2);

`ifdef UART_TX_PARITY_EN
      // Seven data bits, odd parity, word 0x01: parity bit is 0.
      @(posedge clk);
      #1 d3_words = 1;
      w = 0;
      while (d3_sout !== 1'b0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("p7_start", d3_sout, 0);
      repeat (4) @(negedge clk);
      chk("p7_d0", d3_sout, 1);
      repeat (29) @(negedge clk);
      chk("p7_parity", d3_sout, 0);
      repeat (4) @(negedge clk);
      chk("p7_stop", d3_sout, 1);
      repeat (3) @(negedge clk);
      chk("p7_done", d3_done, 1);
      chk("p7_idle", d3_busy, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises words from a show-ahead FIFO onto a single TX line. Data width, stop-bit count and bit period are configurable; an optional parity bit is available at compile time. Back-to-back frames are sent with no idle gap between them. The block sits between the packetizer's TX FIFO and the device pin, and replaces the fixed 8N1 transmitter.

## Interface
- `CLKS_PER_BIT`, default 5208 (50 MHz / 9600 baud): clock cycles per serial bit; legal values ≥ 2.
- `DATA_BITS`, default 8: payload bits per frame; legal values 5–9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, default 0: parity sense, 0 = even, 1 = odd; used only when parity is compiled in.

- `clk`  in  1  — sole clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `tx_ready`  in  1  — downstream permits a new frame; sampled only at frame accept.
- `fifo_empty`  in  1  — FIFO has no data.
- `fifo_data_out`  in  DATA_BITS  — FIFO head word; valid whenever `fifo_empty` = 0.
- `fifo_read`  out  1  — one-cycle pop strobe.
- `serial_out`  out  1  — TX line; idles high.
- `tx_busy`  out  1  — a frame is in progress.
- `tx_done`  out  1  — one-cycle pulse at the end of each frame.

## Operation
- **States:** IDLE, START, DATA, PARITY (only when compiled in), STOP.
- **Accept condition:** `~fifo_empty & tx_ready`, evaluated in IDLE or in the last cycle of the last stop bit.
- **On accept (clock edge E):**
  - `fifo_data_out` is latched into the shift register.
  - `fifo_read` is 1 during the cycle after E.
  - `serial_out` goes to 0, state goes to START and `tx_busy` goes to 1, all on edge E.
- **Bit sequencing:**
  - Every bit is held for exactly CLKS_PER_BIT cycles.
  - The bit counter runs from 0 to CLKS_PER_BIT−1. Its width is `$clog2(CLKS_PER_BIT)`, and it never wraps mid-bit.
- **DATA:** sends DATA_BITS bits, LSB first. The data index is `$clog2(DATA_BITS+1)` bits wide.
- **PARITY:** one bit.
  - Even: XOR of the payload.
  - Odd: inverted XOR of the payload.
  - Computed from the latched word, never from the live FIFO output.
- **STOP:** line high for STOP_BITS × CLKS_PER_BIT cycles.
- **End of the last stop bit:**
  - `tx_done` pulses for 1 cycle.
  - If the accept condition holds on that edge: go straight to START. `tx_busy` stays 1 and there is zero idle time between frames.
  - Otherwise: go to IDLE and `tx_busy` drops to 0.
- **Mid-frame inputs:** `tx_ready` and `fifo_empty` changing mid-frame have no effect on the frame in flight.
- **Illegal state encoding:** return to IDLE with `serial_out` = 1.

## Timing
- **Reset values:**
  - `serial_out` = 1.
  - `fifo_read`, `tx_busy`, `tx_done` = 0.
  - State IDLE, all counters 0.
- **Reset mid-frame:**
  - The line goes high immediately, without waiting for a clock edge.
  - The frame is aborted; the word already popped is lost.
  - No `tx_done` is generated.
- **Frame length:** CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS) cycles, where P = 1 with parity and 0 without.
- **Latency:** start-bit falling edge occurs on the accept edge (0 cycles after the FIFO shows data while IDLE and tx_ready).
- **Pop count:** `fifo_read` never asserts when `fifo_empty` = 1, and asserts at most once per frame.
- **Timing of `tx_done` and `tx_busy`:**
  - `tx_done` is asserted in the same cycle that the next state (IDLE or START) becomes visible.
  - On the IDLE path, `tx_busy` falls in that same cycle.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:**
  - The PARITY state exists; one parity bit per frame follows the data bits, with its sense set by PARITY_ODD.
  - Frame = 1 start + DATA_BITS data + 1 parity + STOP_BITS stop.
- **Undefined:**
  - No PARITY state and no parity logic; DATA goes directly to STOP.
  - PARITY_ODD is ignored.

## Test plan
- **8N1, single byte:** CLKS_PER_BIT=4, DATA_BITS=8, no parity; send 0xA5.
  - Line pattern, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_busy` high for 40 cycles; one `fifo_read`; one `tx_done`.
- **Back-to-back:** FIFO holds 0x00 then 0xFF, tx_ready high.
  - Second start bit begins exactly 40 cycles after the first.
  - `tx_busy` never drops between frames; 2 `fifo_read` pulses; 2 `tx_done` pulses.
- **Parity (`UART_TX_PARITY_EN` defined):**
  - 0xA5 with even parity: parity bit 0, frame 44 cycles.
  - DATA_BITS=7, PARITY_ODD=1, word 0x01: parity bit 0.
- **Two stop bits:** STOP_BITS=2, send 0x3C; line high for 8 cycles after bit 7 before the next start bit.
- **Flow control:**
  - tx_ready=0 with a non-empty FIFO: no `fifo_read` and the line stays high indefinitely.
  - Raising tx_ready starts a frame on the next edge.
  - Dropping tx_ready mid-frame leaves that frame unaltered.
- **Reset mid-frame:** assert `rst` during data bit 3.
  - `serial_out` goes to 1 without waiting for a clock edge, and all status outputs clear.
  - After release, the next FIFO word is sent as a complete, correct frame.
